// File: rtl/dbg_dma_pkg.sv
// Shared definitions for the debug DMA engine: register map, CTRL/STATUS bits, FSM codes, bank decode.
// Latency: n/a (constants and a pure function).
// Backpressure: n/a.
package dbg_dma_pkg;

    // Register word offsets within the window (dma_addr_i[2:0])
    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_LEN    = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_COUNT  = 3'd5;

    // CTRL bit indices
    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;
    localparam int CTRL_CLR   = 2;

    // STATUS bit indices
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_ABORTED = 3;

    // Copy-engine state encodings
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD_ISSUE = 3'd1;
    localparam logic [2:0] ST_RD_WAIT  = 3'd2;
    localparam logic [2:0] ST_WR_ISSUE = 3'd3;
    localparam logic [2:0] ST_FINISH   = 3'd4;

    // STATUS register layout, msb first
    typedef struct packed {
        logic aborted;
        logic err;
        logic done;
        logic busy;
    } status_t;

    // One-hot csram bank select from word-address bits [11:10]
    function automatic logic [3:0] bank_cen(input logic [1:0] bank);
        logic [3:0] cen;
        cen       = 4'b0000;
        cen[bank] = 1'b1;
        return cen;
    endfunction

endpackage

// File: rtl/dbg_dma_engine_if.sv
// Bridge-side register port plus the shared 4-bank csram port of the debug DMA engine.
// Latency: n/a (wires only).
// Backpressure: csram_dbg_en_i stalls the engine; the register port has none.
interface dbg_dma_engine_if;
    logic [31:0] dma_addr_i;
    logic        dma_write_i;
    logic [31:0] dma_wdata_i;
    logic [31:0] dma_rdata_o;
    logic        csram_dbg_en_i;
    logic [3:0]  mem_cen_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_d_o;
    logic [3:0]  mem_wen_o;
    logic [31:0] mem_q_i;

    // Bridge / csram side
    modport master (
        output dma_addr_i, dma_write_i, dma_wdata_i, csram_dbg_en_i, mem_q_i,
        input  dma_rdata_o, mem_cen_o, mem_addr_o, mem_d_o, mem_wen_o
    );

    // Engine side
    modport slave (
        input  dma_addr_i, dma_write_i, dma_wdata_i, csram_dbg_en_i, mem_q_i,
        output dma_rdata_o, mem_cen_o, mem_addr_o, mem_d_o, mem_wen_o
    );
endinterface

// File: rtl/dbg_dma_regs.sv
// Register window of the debug DMA engine: write decode, SRC/DST/LEN and sticky status flags, read mux.
// Latency: writes take effect on the strobe edge; read data is combinational from the address.
// Backpressure: none; config writes and START arriving while busy are dropped and flag err.
module dbg_dma_regs
    import dbg_dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'hf000_0000,
    parameter int          LEN_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      dma_addr,
    input  logic             dma_write,
    input  logic [31:0]      dma_wdata,
    output logic [31:0]      dma_rdata,
    input  logic             busy,
    input  logic             set_done,
    input  logic             set_aborted,
    input  logic [LEN_W-1:0] count,
    output logic [31:0]      src,
    output logic [31:0]      dst,
    output logic [LEN_W-1:0] len,
    output logic             start_cmd,
    output logic             abort_cmd,
    output logic             clr_cmd
);

    logic       hit;
    logic [2:0] off;
    logic       cfg_wr;
    logic       ctrl_wr;
    logic       set_err;
    logic       done_q;
    logic       err_q;
    logic       aborted_q;
    status_t    status;
    logic       unused_addr;

    // Only the top nibble selects the window; the word offset is in [2:0]
    assign hit         = (dma_addr[31:28] == BASE_ADDRESS[31:28]);
    assign off         = dma_addr[2:0];
    assign unused_addr = ^dma_addr[27:3];

    assign cfg_wr  = dma_write && hit && (off == REG_SRC || off == REG_DST || off == REG_LEN);
    assign ctrl_wr = dma_write && hit && (off == REG_CTRL);

    // ABORT masks START when both bits come in one write
    assign abort_cmd = ctrl_wr && dma_wdata[CTRL_ABORT];
    assign start_cmd = ctrl_wr && dma_wdata[CTRL_START] && !dma_wdata[CTRL_ABORT];
    assign clr_cmd   = ctrl_wr && dma_wdata[CTRL_CLR];
    assign set_err   = busy && (cfg_wr || start_cmd);

    // Transfer configuration, frozen while a copy is running
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            src <= '0;
            dst <= '0;
            len <= '0;
        end else if (cfg_wr && !busy) begin
            case (off)
                REG_SRC: src <= dma_wdata;
                REG_DST: dst <= dma_wdata;
                default: len <= dma_wdata[LEN_W-1:0];
            endcase
        end
    end

    // Sticky status flags; a set in the same cycle as CLR_STATUS wins
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            if (set_done)         done_q    <= 1'b1;
            else if (clr_cmd)     done_q    <= 1'b0;
            if (set_err)          err_q     <= 1'b1;
            else if (clr_cmd)     err_q     <= 1'b0;
            if (set_aborted)      aborted_q <= 1'b1;
            else if (clr_cmd)     aborted_q <= 1'b0;
        end
    end

    assign status = '{aborted: aborted_q, err: err_q, done: done_q, busy: busy};

    // Combinational read-back; offsets 3, 6, 7 and out-of-window addresses read 0
    always_comb begin
        dma_rdata = '0;
        if (hit) begin
            case (off)
                REG_SRC:    dma_rdata = src;
                REG_DST:    dma_rdata = dst;
                REG_LEN:    dma_rdata = 32'(len);
                REG_STATUS: dma_rdata = {28'd0, status};
                REG_COUNT:  dma_rdata = 32'(count);
                default:    dma_rdata = '0;
            endcase
        end
    end

endmodule

// File: rtl/dbg_dma_engine.sv
// Debug DMA engine: register window on the bridge DMA port plus a csram word-copy engine (irq under DBG_DMA_IRQ_EN).
// Latency: READ_LAT+2 cycles per word when unblocked, plus one FINISH cycle per transfer.
// Backpressure: holds in RD_ISSUE/WR_ISSUE with all memory outputs at 0 while csram_dbg_en_i is high.
module dbg_dma_engine
    import dbg_dma_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'hf000_0000,
    parameter int          READ_LAT     = 2,
    parameter int          LEN_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    dbg_dma_engine_if.slave  bus,
    output logic             busy_o,
    output logic             irq_o
);

    localparam logic [7:0]       WAIT_LAST = 8'(READ_LAT - 1);
    localparam logic [LEN_W-1:0] ONE       = LEN_W'(1);

    logic [2:0]       state;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] count_q;
    logic [31:0]      data_q;
    logic [7:0]       wait_cnt;

    logic [31:0]      cfg_src;
    logic [31:0]      cfg_dst;
    logic [LEN_W-1:0] cfg_len;
    logic             start_cmd;
    logic             abort_cmd;
    logic             clr_cmd;

    logic             active;
    logic             abort_now;
    logic             issue_rd;
    logic             issue_wr;
    logic             last_word;
    logic             set_done;

    logic [3:0]       mem_cen;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_d;
    logic [3:0]       mem_wen;

    dbg_dma_regs #(
        .BASE_ADDRESS (BASE_ADDRESS),
        .LEN_W        (LEN_W)
    ) u_regs (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .dma_addr    (bus.dma_addr_i),
        .dma_write   (bus.dma_write_i),
        .dma_wdata   (bus.dma_wdata_i),
        .dma_rdata   (bus.dma_rdata_o),
        .busy        (active),
        .set_done    (set_done),
        .set_aborted (abort_now),
        .count       (count_q),
        .src         (cfg_src),
        .dst         (cfg_dst),
        .len         (cfg_len),
        .start_cmd   (start_cmd),
        .abort_cmd   (abort_cmd),
        .clr_cmd     (clr_cmd)
    );

    assign active    = (state != ST_IDLE);
    assign busy_o    = active;
    assign abort_now = abort_cmd && active;
    assign last_word = (count_q == ONE);

    // An ABORT strobe suppresses any access in its own cycle
    assign issue_rd = (state == ST_RD_ISSUE) && !bus.csram_dbg_en_i && !abort_cmd;
    assign issue_wr = (state == ST_WR_ISSUE) && !bus.csram_dbg_en_i && !abort_cmd;

    assign set_done = !abort_now &&
                      ((state == ST_FINISH) ||
                       ((state == ST_IDLE) && start_cmd && (cfg_len == '0)));

    // Memory port is all-zero unless issuing, so it can be OR-merged with the bridge
    always_comb begin
        mem_cen  = '0;
        mem_addr = '0;
        mem_d    = '0;
        mem_wen  = '0;
        if (issue_rd) begin
            mem_cen  = bank_cen(src_q[11:10]);
            mem_addr = src_q;
        end else if (issue_wr) begin
            mem_cen  = bank_cen(dst_q[11:10]);
            mem_addr = dst_q;
            mem_d    = data_q;
            mem_wen  = 4'b1111;
        end
    end

    assign bus.mem_cen_o  = mem_cen;
    assign bus.mem_addr_o = mem_addr;
    assign bus.mem_d_o    = mem_d;
    assign bus.mem_wen_o  = mem_wen;

    // Copy FSM and datapath; ABORT overrides every non-idle state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            src_q    <= '0;
            dst_q    <= '0;
            count_q  <= '0;
            data_q   <= '0;
            wait_cnt <= '0;
        end else if (abort_now) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_cmd && (cfg_len != '0)) begin
                        src_q   <= cfg_src;
                        dst_q   <= cfg_dst;
                        count_q <= cfg_len;
                        state   <= ST_RD_ISSUE;
                    end
                end
                ST_RD_ISSUE: begin
                    if (issue_rd) begin
                        wait_cnt <= '0;
                        state    <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // Read data is captured regardless of bridge ownership
                    if (wait_cnt == WAIT_LAST) begin
                        data_q <= bus.mem_q_i;
                        state  <= ST_WR_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_WR_ISSUE: begin
                    if (issue_wr) begin
                        src_q   <= src_q + 32'd1;
                        dst_q   <= dst_q + 32'd1;
                        count_q <= count_q - ONE;
                        state   <= last_word ? ST_FINISH : ST_RD_ISSUE;
                    end
                end
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

`ifdef DBG_DMA_IRQ_EN
    logic irq_q;

    // Level interrupt: raised entering FINISH or on abort, dropped by CLR_STATUS
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else if ((issue_wr && last_word) || abort_now) begin
            irq_q <= 1'b1;
        end else if (clr_cmd) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_dbg_dma_engine.sv
// Directed self-checking bench for dbg_dma_engine with a READ_LAT=2 csram model.
// Latency: n/a.
// Backpressure: csram_dbg_en_i driven by the stimulus to exercise yielding.
module tb_dbg_dma_engine;
    import dbg_dma_pkg::*;

    localparam logic [31:0] BASE = 32'hf000_0000;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    logic irq;

    int n_cmp = 0;
    int n_err = 0;

    dbg_dma_engine_if bus();

    dbg_dma_engine #(
        .BASE_ADDRESS (BASE),
        .READ_LAT     (2),
        .LEN_W        (16)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .busy_o (busy),
        .irq_o  (irq)
    );

    always #5 clk = ~clk;

    // csram content is a fixed function of the word address
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    // Two-stage read pipeline: data valid two cycles after issue, poison otherwise
    logic [31:0] rd_pipe = 32'h0;
    logic [31:0] q_pipe  = 32'h0;
    always @(posedge clk) begin
        rd_pipe <= (bus.mem_cen_o != 4'b0 && bus.mem_wen_o == 4'b0) ? pat(bus.mem_addr_o) : 32'hDEAD_BEEF;
        q_pipe  <= rd_pipe;
    end
    assign bus.mem_q_i = q_pipe;

    // Access log sampled mid-cycle
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [3:0]  wr_cen_q[$];
    logic [31:0] rd_addr_q[$];
    logic [3:0]  rd_cen_q[$];
    int cen_pulses = 0;
    int hold_viol  = 0;
    int zero_viol  = 0;

    always @(negedge clk) begin
        if (bus.mem_cen_o != 4'b0) begin
            cen_pulses <= cen_pulses + 1;
            if (bus.csram_dbg_en_i) hold_viol <= hold_viol + 1;
            if (bus.mem_wen_o != 4'b0) begin
                wr_addr_q.push_back(bus.mem_addr_o);
                wr_data_q.push_back(bus.mem_d_o);
                wr_cen_q.push_back(bus.mem_cen_o);
            end else begin
                rd_addr_q.push_back(bus.mem_addr_o);
                rd_cen_q.push_back(bus.mem_cen_o);
            end
        end else if (bus.mem_addr_o != 32'h0 || bus.mem_d_o != 32'h0 || bus.mem_wen_o != 4'h0) begin
            zero_viol <= zero_viol + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic reg_wr(input logic [2:0] off, input logic [31:0] val);
        @(posedge clk);
        #1;
        bus.dma_addr_i  = BASE | {29'd0, off};
        bus.dma_wdata_i = val;
        bus.dma_write_i = 1'b1;
        @(posedge clk);
        #1;
        bus.dma_write_i = 1'b0;
        bus.dma_wdata_i = 32'h0;
    endtask

    task automatic reg_rd(input logic [2:0] off, output logic [31:0] val);
        bus.dma_addr_i = BASE | {29'd0, off};
        #1;
        val = bus.dma_rdata_o;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        logic [31:0] st;
        bit seen;
        seen = 1'b0;
        cyc  = -1;
        for (int i = 1; i <= budget && !seen; i++) begin
            @(posedge clk);
            #1;
            reg_rd(REG_STATUS, st);
            if (st[STAT_DONE]) begin
                seen = 1'b1;
                cyc  = i;
            end
        end
    endtask

    task automatic check_xfer(input string tag, input int wb, input int rb,
                              input logic [31:0] src0, input logic [31:0] dst0,
                              input logic [3:0] wcen, input int n);
        check_eq({tag, "_nrd"}, 32'(rd_addr_q.size() - rb), 32'(n));
        check_eq({tag, "_nwr"}, 32'(wr_addr_q.size() - wb), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (rb + i < rd_addr_q.size())
                check_eq($sformatf("%s_ra%0d", tag, i), rd_addr_q[rb + i], src0 + 32'(i));
            if (wb + i < wr_addr_q.size()) begin
                check_eq($sformatf("%s_wa%0d", tag, i), wr_addr_q[wb + i], dst0 + 32'(i));
                check_eq($sformatf("%s_wd%0d", tag, i), wr_data_q[wb + i], pat(src0 + 32'(i)));
                check_eq($sformatf("%s_wc%0d", tag, i), {28'd0, wr_cen_q[wb + i]}, {28'd0, wcen});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int cyc;
        int wb;
        int rb;
        int cp;

        rst                = 1'b1;
        bus.dma_addr_i     = 32'h0;
        bus.dma_write_i    = 1'b0;
        bus.dma_wdata_i    = 32'h0;
        bus.csram_dbg_en_i = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", {31'd0, busy}, 32'h0);
        check_eq("rst_irq", {31'd0, irq}, 32'h0);
        check_eq("rst_cen", {28'd0, bus.mem_cen_o}, 32'h0);
        rst = 1'b0;
        reg_rd(REG_STATUS, v); check_eq("rst_status", v, 32'h0);
        reg_rd(REG_SRC, v);    check_eq("rst_src", v, 32'h0);

        // Readback
        reg_wr(REG_SRC, 32'h10);
        reg_wr(REG_DST, 32'h410);
        reg_wr(REG_LEN, 32'h3);
        reg_rd(REG_SRC, v);    check_eq("rb_src", v, 32'h10);
        reg_rd(REG_DST, v);    check_eq("rb_dst", v, 32'h410);
        reg_rd(REG_LEN, v);    check_eq("rb_len", v, 32'h3);
        reg_rd(REG_STATUS, v); check_eq("rb_status", v, 32'h0);
        reg_rd(3'd6, v);       check_eq("rb_off6", v, 32'h0);
        check_eq("rb_mem_addr", bus.mem_addr_o, 32'h0);
        check_eq("rb_mem_wen", {28'd0, bus.mem_wen_o}, 32'h0);

        // ABORT together with START from IDLE: nothing starts
        cp = cen_pulses;
        reg_wr(REG_CTRL, 32'h3);
        repeat (4) @(posedge clk);
        #1;
        check_eq("abst_busy", {31'd0, busy}, 32'h0);
        reg_rd(REG_STATUS, v); check_eq("abst_status", v, 32'h0);
        check_eq("abst_pulses", 32'(cen_pulses - cp), 32'h0);

        // Plain 3-word copy into bank 1
        wb = wr_addr_q.size(); rb = rd_addr_q.size();
        reg_wr(REG_CTRL, 32'h1);
        wait_done(40, cyc);
        check_eq("copy_done_cyc", 32'(cyc), 32'd13);
        check_xfer("copy", wb, rb, 32'h10, 32'h410, 4'b0010, 3);
        reg_rd(REG_STATUS, v); check_eq("copy_status", v, 32'h2);
        reg_rd(REG_COUNT, v);  check_eq("copy_count", v, 32'h0);
        reg_wr(REG_CTRL, 32'h4);
        reg_rd(REG_STATUS, v); check_eq("clr_status", v, 32'h0);

        // Contention on word 2's read issue for 10 cycles
        reg_wr(REG_SRC, 32'h20);
        reg_wr(REG_DST, 32'h30);
        wb = wr_addr_q.size(); rb = rd_addr_q.size();
        reg_wr(REG_CTRL, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        bus.csram_dbg_en_i = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        bus.csram_dbg_en_i = 1'b0;
        wait_done(40, cyc);
        check_eq("hold_done_cyc", 32'(cyc), 32'd9);
        check_eq("hold_viol", 32'(hold_viol), 32'h0);
        check_xfer("hold", wb, rb, 32'h20, 32'h30, 4'b0001, 3);
        reg_wr(REG_CTRL, 32'h4);

        // LEN=0: immediate done, no memory access
        reg_wr(REG_LEN, 32'h0);
        cp = cen_pulses;
        reg_wr(REG_CTRL, 32'h1);
        reg_rd(REG_STATUS, v); check_eq("len0_status", v, 32'h2);
        repeat (5) @(posedge clk);
        #1;
        check_eq("len0_pulses", 32'(cen_pulses - cp), 32'h0);
        reg_wr(REG_CTRL, 32'h4);

        // START and config write while busy: err, transfer unaffected
        reg_wr(REG_SRC, 32'h10);
        reg_wr(REG_DST, 32'h500);
        reg_wr(REG_LEN, 32'h3);
        wb = wr_addr_q.size(); rb = rd_addr_q.size();
        reg_wr(REG_CTRL, 32'h1);
        reg_wr(REG_CTRL, 32'h1);
        reg_wr(REG_SRC, 32'h99);
        reg_rd(REG_SRC, v);    check_eq("busy_src_kept", v, 32'h10);
        wait_done(40, cyc);
        check_eq("busy_done_cyc", 32'(cyc), 32'd9);
        reg_rd(REG_STATUS, v); check_eq("busy_status", v, 32'h6);
        check_xfer("busy", wb, rb, 32'h10, 32'h500, 4'b0010, 3);
        reg_wr(REG_CTRL, 32'h4);

        // ABORT during word 2's write cycle
        reg_wr(REG_DST, 32'h600);
        wb = wr_addr_q.size();
        reg_wr(REG_CTRL, 32'h1);
        repeat (6) @(posedge clk);
        reg_wr(REG_CTRL, 32'h2);
        check_eq("abort_busy", {31'd0, busy}, 32'h0);
        reg_rd(REG_STATUS, v); check_eq("abort_status", v, 32'h8);
        reg_rd(REG_COUNT, v);  check_eq("abort_count", v, 32'h2);
`ifdef DBG_DMA_IRQ_EN
        check_eq("abort_irq", {31'd0, irq}, 32'h1);
`else
        check_eq("abort_irq", {31'd0, irq}, 32'h0);
`endif
        repeat (10) @(posedge clk);
        #1;
        check_eq("abort_nwr", 32'(wr_addr_q.size() - wb), 32'h1);
        reg_wr(REG_CTRL, 32'h4);
        check_eq("clr_irq", {31'd0, irq}, 32'h0);
        reg_rd(REG_STATUS, v); check_eq("abort_clr_status", v, 32'h0);

        // Address wrap across 2^32 and bank change on the read side
        reg_wr(REG_SRC, 32'hFFFF_FFFF);
        reg_wr(REG_DST, 32'h700);
        reg_wr(REG_LEN, 32'h2);
        wb = wr_addr_q.size(); rb = rd_addr_q.size();
        reg_wr(REG_CTRL, 32'h1);
        wait_done(40, cyc);
        check_eq("wrap_done_cyc", 32'(cyc), 32'd9);
        check_xfer("wrap", wb, rb, 32'hFFFF_FFFF, 32'h700, 4'b0010, 2);
        if (rb + 1 < rd_addr_q.size()) begin
            check_eq("wrap_rcen0", {28'd0, rd_cen_q[rb]}, 32'h8);
            check_eq("wrap_rcen1", {28'd0, rd_cen_q[rb + 1]}, 32'h1);
        end
        reg_wr(REG_CTRL, 32'h4);

        // Reset during a write cycle: no partial write, everything back to 0
        reg_wr(REG_SRC, 32'h10);
        reg_wr(REG_DST, 32'h800);
        reg_wr(REG_LEN, 32'h3);
        wb = wr_addr_q.size();
        reg_wr(REG_CTRL, 32'h1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", {31'd0, busy}, 32'h0);
        check_eq("mrst_cen", {28'd0, bus.mem_cen_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mrst_nwr", 32'(wr_addr_q.size() - wb), 32'h0);
        reg_rd(REG_SRC, v);   check_eq("mrst_src", v, 32'h0);
        reg_rd(REG_COUNT, v); check_eq("mrst_count", v, 32'h0);

        check_eq("idle_outputs_zero", 32'(zero_viol), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dbg_dma_engine.md
Name: dbg_dma_engine

Overview:
- Downstream consumer of the UART debug bridge's DMA port. It decodes bridge writes to the 0xF000_0000 region into a small register file.
- Runs a word-copy engine that moves LEN words from one csram word address to another over the same 4-bank csram port the bridge uses.
- Yields the csram port whenever the bridge holds it (csram_dbg_en high).

Parameters:
- BASE_ADDRESS, 32'hf0000000: register window base. Only addr[31:28]==BASE_ADDRESS[31:28] is decoded.
- READ_LAT, 2: cycles from csram read issue (cen+addr driven) to csram_q valid.
- LEN_W, 16: width of the LEN and COUNT registers.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- dma_addr_i  in  32  register word address from bridge
- dma_write_i  in  1  one-cycle write strobe
- dma_wdata_i  in  32  write data
- dma_rdata_o  out  32  register read data, combinational from dma_addr_i
- csram_dbg_en_i  in  1  bridge owns csram; engine must not drive the port
- mem_cen_o  out  4  one-hot bank select, from addr[11:10]
- mem_addr_o  out  32  csram word address
- mem_d_o  out  32  csram write data
- mem_wen_o  out  4  write mask (4'b1111 on write, else 0)
- mem_q_i  in  32  csram read data
- busy_o  out  1  engine active
- irq_o  out  1  done interrupt (see Optional Feature)

Behaviour:
- Register map, word offset dma_addr_i[2:0]:
  - 0 SRC (rw)
  - 1 DST (rw)
  - 2 LEN (rw, [LEN_W-1:0])
  - 3 CTRL (wo): bit0 START, bit1 ABORT, bit2 CLR_STATUS
  - 4 STATUS (ro): bit0 busy, bit1 done, bit2 err, bit3 aborted
  - 5 COUNT (ro): words remaining
  - 6,7 read as 0.
- Writes to SRC/DST/LEN while busy are ignored and set err.
- Reset: all registers and outputs 0; state IDLE.
- Memory outputs are all 0 in any cycle the engine is not issuing, so they can be OR-merged with the bridge outputs.
- FSM states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, FINISH:
  - IDLE: START & LEN!=0 → latch src/dst/count; busy=1; go to RD_ISSUE. START & LEN==0 → done=1, no memory access, stay IDLE. START while busy → ignored, err=1.
  - RD_ISSUE: if csram_dbg_en_i, hold. Else drive cen/addr=src for 1 cycle, go to RD_WAIT.
  - RD_WAIT: count READ_LAT-1 cycles, then capture mem_q_i into the data register and go to WR_ISSUE. The capture happens even if csram_dbg_en_i rises meanwhile.
  - WR_ISSUE: if csram_dbg_en_i, hold. Else drive cen/addr=dst, d=data, wen=4'b1111 for 1 cycle. Then src+=1, dst+=1, count-=1. Go to FINISH if count was 1, else RD_ISSUE.
  - FINISH: busy=0, done=1, go to IDLE.
- Throughput when unblocked: READ_LAT+2 cycles per word.
- Address increments wrap modulo 2^32. A bank change mid-transfer simply follows addr[11:10].
- ABORT in any non-IDLE state: go to IDLE next cycle, busy=0, aborted=1, no write issued that cycle. If ABORT and START arrive in the same write, ABORT wins.
- CLR_STATUS clears done/err/aborted. If set in the same cycle as done is set, done wins.
- Reset mid-transfer: immediate return to IDLE, outputs 0, no partial write.

Optional Feature:
- Macro DBG_DMA_IRQ_EN.
- Defined: irq_o is a level, set on entry to FINISH or on abort, cleared by CLR_STATUS.
- Undefined: irq_o tied to 0 and the irq flop is absent; STATUS is unchanged.

Decomposition:
- Package dbg_dma_pkg holds:
  - register offsets
  - CTRL/STATUS bit indices
  - FSM state encodings (3-bit)
  - the bank-decode function addr[11:10] → one-hot cen
- One sub-module, dbg_dma_regs: decode, register storage, and the read mux. The FSM and datapath stay in the top.

Test Plan:
- Reset and readback: SRC=0x10, DST=0x410, LEN=3 → reads return 0x10/0x410/3; STATUS=0; all mem outputs 0.
- Copy: preload csram[0x10..0x12]=A,B,C, START → writes to 0x410..0x412 in bank 1 (cen=4'b0010) with A,B,C; done=1 after 3×(READ_LAT+2)+1 cycles.
- Contention: hold csram_dbg_en_i high during word 2's RD_ISSUE for 10 cycles → no engine mem activity during the hold; copy completes correctly afterwards.
- LEN=0 START → done=1 the next cycle with zero mem_cen_o pulses. START while busy → err=1 and the transfer is unaffected.
- ABORT after the first write → aborted=1, COUNT=2, no further writes. With DBG_DMA_IRQ_EN, irq_o=1 until CLR_STATUS.
- Wrap: SRC=0xFFFFFFFF, LEN=2 → second read address is 0x00000000.
